// File: rtl/controlador_de_partida_pkg.sv
// =============================================================================
// controlador_de_partida_pkg
// State encoding, board dimensions and the ship-cells-hit check for the game sequencer.
// Revision: 1.0
// =============================================================================
`default_nettype none

package controlador_de_partida_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        JOGANDO = 3'd1,
        AGUARDA = 3'd2,
        AVALIA  = 3'd3,
        VITORIA = 3'd4,
        DERROTA = 3'd5
    } estado_t;

    localparam int N_COLUNAS = 5;
    localparam int N_LINHAS  = 7;

    // An empty map must never count as a win, so at least one ship cell is required.
    function automatic logic acertos_completos(
        input logic [N_COLUNAS-1:0][N_LINHAS-1:0] mapa,
        input logic [N_COLUNAS-1:0][N_LINHAS-1:0] matriz
    );
        logic completo;
        logic tem_navio;
        completo  = 1'b1;
        tem_navio = 1'b0;
        for (int c = 0; c < N_COLUNAS; c++) begin
            if ((matriz[c] & mapa[c]) != mapa[c]) completo = 1'b0;
            if (mapa[c] != '0) tem_navio = 1'b1;
        end
        return completo & tem_navio;
    endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_de_partida_sincronizador_borda.sv
// =============================================================================
// sincronizador_borda
// Multi-flop synchroniser for a raw button followed by a rising-edge one-cycle pulse.
// Revision: 1.0
// =============================================================================
`default_nettype none

module sincronizador_borda #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_i,
    output logic pulso_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   anterior_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            anterior_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], botao_i};
            anterior_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulso_o = sync_q[SYNC_STAGES-1] & ~anterior_q;

endmodule

`default_nettype wire

// File: rtl/controlador_de_partida.sv
// =============================================================================
// controlador_de_partida
// Game sequencer: button handling, move timer/counter and win/lose FSM for the attack datapath.
// Revision: 1.0
// =============================================================================
`default_nettype none

module controlador_de_partida
    import controlador_de_partida_pkg::*;
#(
    parameter int unsigned TEMPO_JOGADA = 500_000_000,
    parameter int unsigned MAX_JOGADAS  = 35,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                botao_iniciar,
    input  logic                botao_confirmar,
    input  logic                tem_vida,
    input  logic [N_LINHAS-1:0] mapa0,
    input  logic [N_LINHAS-1:0] mapa1,
    input  logic [N_LINHAS-1:0] mapa2,
    input  logic [N_LINHAS-1:0] mapa3,
    input  logic [N_LINHAS-1:0] mapa4,
    input  logic [N_LINHAS-1:0] matriz0,
    input  logic [N_LINHAS-1:0] matriz1,
    input  logic [N_LINHAS-1:0] matriz2,
    input  logic [N_LINHAS-1:0] matriz3,
    input  logic [N_LINHAS-1:0] matriz4,
    output logic                enable_ataque,
    output logic                confirmar_ataque,
    output logic [2:0]          estado,
    output logic [5:0]          jogadas,
    output logic                venceu,
    output logic                perdeu
);

    localparam logic [31:0] TEMPO_LIMITE = 32'(TEMPO_JOGADA - 32'd1);
    localparam logic [5:0]  JOGADAS_MAX  = 6'(MAX_JOGADAS);

    logic pulso_iniciar;
    logic pulso_confirmar;
    logic acertos;

    estado_t     estado_q,    estado_d;
    logic [31:0] timer_q,     timer_d;
    logic [5:0]  jogadas_q,   jogadas_d;
    logic        enable_q,    enable_d;
    logic        confirmar_q, confirmar_d;
    logic        venceu_q,    venceu_d;
    logic        perdeu_q,    perdeu_d;

    sincronizador_borda #(.SYNC_STAGES(SYNC_STAGES)) u_sync_iniciar (
        .clock   (clock),
        .reset   (reset),
        .botao_i (botao_iniciar),
        .pulso_o (pulso_iniciar)
    );

    sincronizador_borda #(.SYNC_STAGES(SYNC_STAGES)) u_sync_confirmar (
        .clock   (clock),
        .reset   (reset),
        .botao_i (botao_confirmar),
        .pulso_o (pulso_confirmar)
    );

    assign acertos = acertos_completos({mapa4, mapa3, mapa2, mapa1, mapa0},
                                       {matriz4, matriz3, matriz2, matriz1, matriz0});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            timer_q     <= '0;
            jogadas_q   <= '0;
            enable_q    <= 1'b0;
            confirmar_q <= 1'b0;
            venceu_q    <= 1'b0;
            perdeu_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            timer_q     <= timer_d;
            jogadas_q   <= jogadas_d;
            enable_q    <= enable_d;
            confirmar_q <= confirmar_d;
            venceu_q    <= venceu_d;
            perdeu_q    <= perdeu_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        timer_d     = timer_q;
        jogadas_d   = jogadas_q;
        confirmar_d = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (pulso_iniciar) begin
                    estado_d  = JOGANDO;
                    timer_d   = '0;
                    jogadas_d = '0;
                end
            end
            JOGANDO: begin
                // A confirm arriving on the timeout cycle still counts as a move.
                if (pulso_confirmar) begin
                    confirmar_d = 1'b1;
                    timer_d     = '0;
                    estado_d    = AGUARDA;
                    if (jogadas_q < JOGADAS_MAX) jogadas_d = jogadas_q + 6'd1;
                end else if ((TEMPO_JOGADA != 0) && (timer_q == TEMPO_LIMITE)) begin
                    estado_d = DERROTA;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            AGUARDA: estado_d = AVALIA;
            AVALIA: begin
                if (acertos)                        estado_d = VITORIA;
                else if (!tem_vida)                 estado_d = DERROTA;
                else if (jogadas_q == JOGADAS_MAX)  estado_d = DERROTA;
                else                                estado_d = JOGANDO;
            end
            VITORIA, DERROTA: begin
                if (pulso_iniciar) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
        enable_d = (estado_d != OCIOSO);
        venceu_d = (estado_d == VITORIA);
        perdeu_d = (estado_d == DERROTA);
    end

    assign estado           = estado_q;
    assign jogadas          = jogadas_q;
    assign enable_ataque    = enable_q;
    assign confirmar_ataque = confirmar_q;
    assign venceu           = venceu_q;
    assign perdeu           = perdeu_q;

endmodule

`default_nettype wire
